audio_rate_buffer: RTL and testbench
====================================

// Module: audio_rate_buffer
// PURPOSE
//  Rate-matching stereo sample buffer between the NeoGeo sound mixer (YM2610/ADPCM, ~55.5 kHz bursts)
//  and the 48 kHz I2S serializer. Lives entirely in the clk_audio domain; producer strobes arrive pre-synchronised.
//  Absorbs jitter in a small FIFO and presents one held stereo sample per 48 kHz slot.
//  Repeats the last sample on starvation and drops samples on overflow, so the serializer never sees garbage.
// PARAMETERS
//  DEPTH        8    FIFO entries (power of 2, >=4); one entry = {l,r} 32 bits
//  OUT_DIV      512  clk_audio cycles per output sample (24.576 MHz / 48 kHz)
//  START_LEVEL  4    fill level required to leave PRIME (1..DEPTH)
// PORTS
//  clk_audio   in   1                 24.576 MHz audio clock
//  reset_n     in   1                 async active-low reset
//  in_valid    in   1                 one-cycle strobe: in_l/in_r valid
//  in_l        in   16                signed left sample from mixer
//  in_r        in   16                signed right sample from mixer
//  mute        in   1                 force zero output, FIFO keeps draining
//  audio_l     out  16                held left sample to I2S stage
//  audio_r     out  16                held right sample to I2S stage
//  out_strobe  out  1                 one-cycle pulse, coincident with a new audio_l/r value
//  fifo_level  out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  underrun    out  1                 one-cycle pulse: pop requested while empty in RUN
//  overflow    out  1                 one-cycle pulse: push dropped because full
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, FIFO empty, divider 0, state PRIME.
//  - Divider counts 0..OUT_DIV-1 and wraps; "tick" = count==OUT_DIV-1. Tick period exactly OUT_DIV cycles.
//  - On the tick edge audio_l/r load; out_strobe is high the following cycle (new value visible with it).
//    audio_l/r are held constant between strobes.
//  - Push: in_valid && (level<DEPTH || pop same cycle) -> write {in_l,in_r}, wptr wraps mod DEPTH.
//    in_valid && full && no pop -> sample discarded, overflow pulses, FIFO contents untouched.
//  - FSM states: PRIME, RUN.
//    PRIME: on tick output 0/0, no pop. -> RUN when fifo_level>=START_LEVEL (checked every cycle).
//    RUN: on tick with level>0 -> pop head into audio_l/r (0 if mute), level-1 unless push same cycle.
//         on tick with level==0 -> repeat previous audio_l/r (0 if mute), underrun pulses, -> PRIME.
//  - Simultaneous push+pop: both happen, level unchanged; when full, push accepted (not overflow).
//  - Simultaneous push+pop when empty in RUN: underrun wins for output; pushed sample is stored.
//  - mute changes take effect at the next tick only; never glitch mid-slot.
//  - Latency: first input reaches output at the first tick after level reaches START_LEVEL (<= OUT_DIV+1 cycles).
//  - No arithmetic on samples; data passes bit-exact. fifo_level is a registered count, never exceeds DEPTH.
// STRUCTURE
//  - audio_pkg: typedef struct packed {logic signed [15:0] l, r;} stereo_sample_t;
//    constants AUDIO_CLK_HZ=24_576_000, AUDIO_OUT_HZ=48_000; enum rb_state_t {RB_PRIME, RB_RUN}.
//  - One sub-module: audio_sample_fifo (sync FIFO of stereo_sample_t, DEPTH param, push/pop/level/full/empty,
//    first-word-fall-through head). FSM, divider and output registers stay in audio_rate_buffer.
// TESTING
//  1 Reset then idle 2000 cycles -> out_strobe every 512 cycles, audio_l/r==0, underrun never pulses.
//  2 Push 4 samples (L=0x1000+n, R=0x2000+n, n=0..3) -> RUN; next 4 strobes give 0x1000..0x1003 in order.
//  3 Continue from 2 with no pushes -> 5th strobe repeats 0x1003/0x2003, underrun pulses once, state PRIME.
//  4 Push 10 samples back-to-back with DEPTH=8 in PRIME -> overflow pulses twice, fifo_level==8, first 8 kept.
//  5 Steady 55.5 kHz pushes (every 443 cycles) for 2 ms -> overflow pulses, no underrun, output monotone counter with gaps.
//  6 Assert mute mid-slot then drop reset_n mid-RUN -> mute shows 0 at next strobe; reset clears all outputs immediately.

Source files
------------

// File: rtl/audio_rate_buffer_pkg.sv
// Shared types and constants for the audio rate-matching buffer.
package audio_pkg;

    typedef struct packed {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } stereo_sample_t;

    localparam int AUDIO_CLK_HZ = 24_576_000;
    localparam int AUDIO_OUT_HZ = 48_000;
    localparam int AUDIO_DIV    = AUDIO_CLK_HZ / AUDIO_OUT_HZ;

    typedef enum logic {
        RB_PRIME = 1'b0,
        RB_RUN   = 1'b1
    } rb_state_t;

endpackage

// File: rtl/audio_rate_buffer_if.sv
// Producer/consumer bundle of the rate buffer; state is exported for observation.
interface audio_rate_buffer_if #(
    parameter int DEPTH = 8
);
    import audio_pkg::*;
    localparam int LW = $clog2(DEPTH) + 1;

    // in_valid is a one-cycle strobe with no back-pressure: every strobe is either
    // stored or dropped (overflow); out_strobe marks a fresh audio_l/r for one cycle.
    logic               in_valid;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               mute;
    logic signed [15:0] audio_l;
    logic signed [15:0] audio_r;
    logic               out_strobe;
    logic [LW-1:0]      fifo_level;
    logic               underrun;
    logic               overflow;
    rb_state_t          state;

    modport master (
        output in_valid, in_l, in_r, mute,
        input  audio_l, audio_r, out_strobe, fifo_level, underrun, overflow, state
    );

    modport slave (
        input  in_valid, in_l, in_r, mute,
        output audio_l, audio_r, out_strobe, fifo_level, underrun, overflow, state
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous stereo sample FIFO with first-word-fall-through head and registered level.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  stereo_sample_t wdata,
    output stereo_sample_t head,
    output logic [LW-1:0]  level,
    output logic           full,
    output logic           empty
);
    stereo_sample_t mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop_ok)  rptr <= rptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/audio_rate_buffer.sv
// Rate-matching stereo buffer: bursty mixer samples in, one held sample per 48 kHz slot out.
module audio_rate_buffer
    import audio_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int OUT_DIV     = AUDIO_DIV,
    parameter int START_LEVEL = 4,
    localparam int LW = $clog2(DEPTH) + 1,
    localparam int DW = $clog2(OUT_DIV)
) (
    input  logic               clk_audio,
    input  logic               reset_n,
    audio_rate_buffer_if.slave rb
);
    logic [1:0]     rst_sync;
    logic           rst_n;
    logic [DW-1:0]  div_cnt;
    logic           tick;
    rb_state_t      state_q, state_d;
    logic           pop;
    stereo_sample_t head;
    stereo_sample_t out_q;
    logic [LW-1:0]  level;
    logic           full, empty;
    logic           strobe_q, underrun_q, overflow_q;

    // Assertion is immediate; release is delayed two cycles to be clean against clk_audio.
    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign tick = (div_cnt == DW'(OUT_DIV - 1));

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n)    div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DW'(1);
    end

    audio_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_audio),
        .rst_n (rst_n),
        .push  (rb.in_valid),
        .pop   (pop),
        .wdata ({rb.in_l, rb.in_r}),
        .head  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) state_q <= RB_PRIME;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            RB_PRIME: if (level >= LW'(START_LEVEL)) state_d = RB_RUN;
            RB_RUN: begin
                if (tick) begin
                    if (empty) state_d = RB_PRIME;
                    else       pop     = 1'b1;
                end
            end
            default: state_d = RB_PRIME;
        endcase
    end

    // Output sample only moves on a tick, so mute can never glitch mid-slot.
    always_ff @(posedge clk_audio or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (tick) begin
                if (state_q == RB_PRIME || rb.mute) out_q <= '0;
                else if (!empty)                    out_q <= head;
            end
            strobe_q   <= tick;
            underrun_q <= tick && (state_q == RB_RUN) && empty;
            overflow_q <= rb.in_valid && full && !pop;
        end
    end

    assign rb.audio_l    = out_q.l;
    assign rb.audio_r    = out_q.r;
    assign rb.out_strobe = strobe_q;
    assign rb.fifo_level = level;
    assign rb.underrun   = underrun_q;
    assign rb.overflow   = overflow_q;
    assign rb.state      = state_q;
endmodule

// File: tb/tb_audio_rate_buffer.sv
// Directed bench for audio_rate_buffer: priming, ordering, starvation, overflow, rate match, mute/reset.
module tb_audio_rate_buffer;
    import audio_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    audio_rate_buffer_if #(.DEPTH(8)) rb ();

    audio_rate_buffer #(.DEPTH(8), .OUT_DIV(512), .START_LEVEL(4)) dut (
        .clk_audio (clk),
        .reset_n   (reset_n),
        .rb        (rb)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_strobe = -1;
    int underrun_cnt = 0;
    int overflow_cnt = 0;
    int max_level = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: strobe period, captured output samples, event counters.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            last_strobe = -1;
        end else begin
            if (rb.out_strobe) begin
                if (last_strobe >= 0) check_eq("strobe_period", cyc - last_strobe, 512);
                last_strobe = cyc;
                got_q.push_back({rb.audio_l, rb.audio_r});
            end
            if (rb.underrun) underrun_cnt++;
            if (rb.overflow) overflow_cnt++;
            if (int'(rb.fifo_level) > max_level) max_level = int'(rb.fifo_level);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sync_strobe();
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!rb.out_strobe && k < 1200);
        if (!rb.out_strobe) check_eq("sync_timeout", 0, 1);
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_q.size() < n && k < n * 600 + 600) begin
            step(1);
            k++;
        end
        if (got_q.size() < n) check_eq("strobe_timeout", got_q.size(), n);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        rb.in_valid = 1'b1;
        rb.in_l     = l;
        rb.in_r     = r;
        step(1);
        rb.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(3);
    endtask

    task automatic compare_got(input string tag);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check_eq({tag, "_missing"}, 0, exp_q.pop_front());
            end else begin
                check_eq(tag, got_q.pop_front(), exp_q.pop_front());
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [15:0] prev_l;
        bit started;
        int bad, nz, gaps;

        reset_n     = 1'b0;
        rb.in_valid = 1'b0;
        rb.in_l     = '0;
        rb.in_r     = '0;
        rb.mute     = 1'b0;
        step(3);
        check_eq("rst_audio_l", 32'(rb.audio_l), 0);
        check_eq("rst_audio_r", 32'(rb.audio_r), 0);
        check_eq("rst_strobe", 32'(rb.out_strobe), 0);
        check_eq("rst_level", 32'(rb.fifo_level), 0);
        check_eq("rst_flags", {30'd0, rb.underrun, rb.overflow}, 0);
        check_eq("rst_state", 32'(rb.state), 32'(RB_PRIME));

        // 1: idle priming output
        reset_n = 1'b1;
        underrun_cnt = 0;
        got_q.delete();
        step(2000);
        check_eq("idle_strobes", 32'(got_q.size() >= 3), 1);
        nz = 0;
        foreach (got_q[i]) if (got_q[i] != 0) nz++;
        check_eq("idle_zero", nz, 0);
        check_eq("idle_underrun", underrun_cnt, 0);

        // 2: four samples, ordered playout
        sync_strobe();
        for (int n = 0; n < 4; n++) begin
            push(16'h1000 + 16'(n), 16'h2000 + 16'(n));
            exp_q.push_back({16'h1000 + 16'(n), 16'h2000 + 16'(n)});
        end
        got_q.delete();
        underrun_cnt = 0;
        step(3);
        check_eq("run_state", 32'(rb.state), 32'(RB_RUN));
        check_eq("run_level", 32'(rb.fifo_level), 4);
        wait_got(4);
        compare_got("order");

        // 3: starvation repeats last sample
        wait_got(1);
        check_eq("repeat_sample", got_q.pop_front(), 32'h1003_2003);
        check_eq("underrun_once", underrun_cnt, 1);
        check_eq("back_to_prime", 32'(rb.state), 32'(RB_PRIME));
        check_eq("starve_level", 32'(rb.fifo_level), 0);

        // 4: overflow keeps first DEPTH samples
        sync_strobe();
        overflow_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            push(16'h3000 + 16'(n), 16'h4000 + 16'(n));
            if (n < 8) exp_q.push_back({16'h3000 + 16'(n), 16'h4000 + 16'(n)});
        end
        got_q.delete();
        step(2);
        check_eq("ovf_count", overflow_cnt, 2);
        check_eq("ovf_level", 32'(rb.fifo_level), 8);
        wait_got(8);
        compare_got("ovf_kept");

        // 5: steady 55.5 kHz producer
        do_reset();
        overflow_cnt = 0;
        underrun_cnt = 0;
        max_level = 0;
        got_q.delete();
        for (int n = 1; n <= 111; n++) begin
            push(16'(n), 16'(n) ^ 16'h5A5A);
            step(442);
        end
        check_eq("rate_overflow", 32'(overflow_cnt > 0), 1);
        check_eq("rate_underrun", underrun_cnt, 0);
        check_eq("rate_max_level", max_level, 8);
        started = 1'b0;
        prev_l = '0;
        bad = 0;
        nz = 0;
        foreach (got_q[i]) begin
            v = got_q[i];
            if (!started && v == 0) continue;
            if (!started) begin
                started = 1'b1;
                check_eq("rate_first", v, {16'd1, 16'd1 ^ 16'h5A5A});
            end else if (v[31:16] <= prev_l) begin
                bad++;
            end
            if (v[15:0] != (v[31:16] ^ 16'h5A5A)) bad++;
            prev_l = v[31:16];
            nz++;
        end
        check_eq("rate_monotone", bad, 0);
        gaps = int'(prev_l) - nz;
        check_eq("rate_gaps", 32'(gaps > 0), 1);

        // 6: mute at next slot, async reset mid-RUN
        do_reset();
        sync_strobe();
        for (int n = 0; n < 4; n++) push(16'h5000 + 16'(n), 16'h6000 + 16'(n));
        got_q.delete();
        wait_got(1);
        check_eq("pre_mute", got_q.pop_front(), 32'h5000_6000);
        step(256);
        rb.mute = 1'b1;
        step(10);
        check_eq("mute_hold", {rb.audio_l, rb.audio_r}, 32'h5000_6000);
        wait_got(1);
        check_eq("mute_zero", got_q.pop_front(), 0);
        check_eq("mute_drain", 32'(rb.fifo_level), 2);
        step(100);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("areset_level", 32'(rb.fifo_level), 0);
        check_eq("areset_state", 32'(rb.state), 32'(RB_PRIME));
        check_eq("areset_out", {rb.audio_l, rb.audio_r}, 0);
        check_eq("areset_flags", {29'd0, rb.out_strobe, rb.underrun, rb.overflow}, 0);
        rb.mute = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
